// File: rtl/alu_divider_if.sv
// Start/done handshake and operand/result bundle for the ALU divider.
// The master issues requests and the slave is the divider.
interface alu_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_divider.sv
// Multi-cycle unsigned restoring divider. It produces one quotient bit per clock
// and reports each result with a single-cycle done pulse.
module alu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_divider_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dbz;

  logic [2*WIDTH-1:0] w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_q_next;
  logic [WIDTH-1:0]   w_rem_next;

  // The remainder stays below 2^(k) after k steps, so dropping the shifted-out
  // MSB before the WIDTH+1-bit trial subtraction never loses information.
  always_comb begin
    w_shift    = {r_rem, r_q} << 1;
    w_trial    = {1'b0, w_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_divisor};
    w_q_next   = {w_shift[WIDTH-1:1], ~w_trial[WIDTH]};
    w_rem_next = w_trial[WIDTH] ? w_shift[2*WIDTH-1:WIDTH] : w_trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_remd    <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_divisor <= bus.divisor;
            r_q       <= bus.dividend;
            r_rem     <= '0;
            r_cnt     <= CW'(WIDTH);
            if (bus.divisor == '0) begin
              r_quot  <= '1;
              r_remd  <= bus.dividend;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_quot  <= w_q_next;
            r_remd  <= w_rem_next;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: stimulus pushes expected results, and a
// monitor checks done timing, busy, and held result registers every cycle.
module tb_alu_divider;
  localparam int unsigned W = 32;

  logic clk;
  logic reset_n;

  alu_divider_if #(.WIDTH(W)) bus ();
  alu_divider #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           c0;
    int           done_at;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every cycle compares done/busy timing and the result registers.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      logic exp_done;
      logic exp_busy;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      if (sb.size() > 0) begin
        exp_done = (cyc == sb[0].done_at);
        exp_busy = !sb[0].dbz && (cyc >= sb[0].c0) && (cyc < sb[0].c0 + int'(W));
      end
      chk("done", W'(bus.done), W'(exp_done));
      chk("busy", W'(bus.busy), W'(exp_busy));
      if (exp_done) begin
        exp_t e;
        e = sb.pop_front();
        last_q = e.q;
        last_r = e.r;
        last_z = e.dbz;
      end
      chk("quotient", bus.quotient, last_q);
      chk("remainder", bus.remainder, last_r);
      chk("div_by_zero", W'(bus.div_by_zero), W'(last_z));
    end
  end

  // Reference: plain unsigned arithmetic, divide-by-zero returns all ones and the dividend.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dbz     = (b == '0);
    e.q       = e.dbz ? '1 : a / b;
    e.r       = e.dbz ? a : a % b;
    e.c0      = cyc + 1;
    e.done_at = e.dbz ? e.c0 : e.c0 + int'(W);
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < int'(W) + 6 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: done never seen, %0d results outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_empty();
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_busy"}, W'(bus.busy), '0);
    chk({tag, "_done"}, W'(bus.done), '0);
    chk({tag, "_quotient"}, bus.quotient, '0);
    chk({tag, "_remainder"}, bus.remainder, '0);
    chk({tag, "_dbz"}, W'(bus.div_by_zero), '0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run(32'd100, 32'd7);
    run(32'hFFFF_FFFF, 32'd1);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(32'd3, 32'd10);
    run(32'd5, 32'd0);
    run(32'd9, 32'd3);
    run(32'd0, 32'd0);
    run(32'd0, 32'd5);

    // A start pulse during RUN must not queue a second division.
    issue(32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd8;
    bus.divisor  = 32'd2;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_empty();

    // Start held high across a whole operation is accepted only once.
    issue(32'd77, 32'd5);
    bus.start = 1'b1;
    for (int i = 0; i < int'(W) + 6 && sb.size() != 0; i++) @(negedge clk);
    bus.start = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);

    // Reset mid-operation aborts with no done pulse afterwards.
    issue(32'd123456, 32'd789);
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (int'(W) + 4) @(negedge clk);
    run(32'd50, 32'd6);

    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = a;
        3:       b = '1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(a, b);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
